// File: rtl/inst_fetch_if.sv
// Instruction fetch interface: issues one word read per instruction on an SRAM-like bus
// and hands the result to decode over a valid/ready handshake, with redirect flush support.
module inst_fetch_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              fetch_en,
   input  logic              flush,
   input  logic              id_ready_i,
   output logic              inst_valid_o,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              exc_adel_o,
   output logic              pc_advance_o,
   output logic              inst_req,
   output logic              inst_wr,
   output logic [1:0]        inst_size,
   output logic [ADDR_W-1:0] inst_addr,
   input  logic              inst_addr_ok,
   input  logic              inst_data_ok,
   input  logic [DATA_W-1:0] inst_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
      DISCARD,
      VALID
   } state_t;

   state_t            state, next_state;
   logic              kill_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] inst_q;
   logic [ADDR_W-1:0] pc_q;
   logic              exc_q;
   logic              misaligned;

   assign misaligned = (pc_i[1:0] != 2'b00);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (fetch_en && !flush) begin
               next_state = misaligned ? VALID : ADDR;
            end
         end
         ADDR: begin
            if (inst_addr_ok) begin
               next_state = (kill_q || flush) ? DISCARD : DATA;
            end
         end
         DATA: begin
            if (inst_data_ok) begin
               next_state = flush ? IDLE : VALID;
            end else if (flush) begin
               next_state = DISCARD;
            end
         end
         DISCARD: begin
            if (inst_data_ok) begin
               next_state = IDLE;
            end
         end
         VALID: begin
            if (flush || id_ready_i) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // kill_q remembers a redirect seen before the response arrives so that response is dropped.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         kill_q <= 1'b0;
         addr_q <= '0;
         inst_q <= '0;
         pc_q   <= '0;
         exc_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (fetch_en && !flush) begin
                  addr_q <= pc_i;
                  if (misaligned) begin
                     exc_q  <= 1'b1;
                     inst_q <= '0;
                     pc_q   <= pc_i;
                  end
               end
            end
            ADDR: begin
               kill_q <= kill_q | flush;
            end
            DATA: begin
               if (inst_data_ok && !flush) begin
                  inst_q <= inst_rdata;
                  pc_q   <= addr_q;
                  exc_q  <= 1'b0;
               end else if (flush && !inst_data_ok) begin
                  kill_q <= 1'b1;
               end
            end
            DISCARD: begin
               if (inst_data_ok) begin
                  kill_q <= 1'b0;
               end
            end
            VALID: begin
               if (flush || id_ready_i) begin
                  exc_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign inst_req     = (state == ADDR);
   assign inst_valid_o = (state == VALID);
   assign pc_advance_o = (state == VALID) && id_ready_i && !flush;
   assign inst_addr    = addr_q;
   assign inst_o       = inst_q;
   assign pc_o         = pc_q;
   assign exc_adel_o   = exc_q;
   assign inst_wr      = 1'b0;
   assign inst_size    = 2'b10;

endmodule

// File: tb/tb_inst_fetch_if.sv
// Testbench for inst_fetch_if: directed scenarios followed by random bus/handshake traffic,
// all compared against a transaction-level reference model.
module tb_inst_fetch_if;

   logic        clk;
   logic        resetn;
   logic [31:0] pc_i;
   logic        fetch_en;
   logic        flush;
   logic        id_ready_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic        exc_adel_o;
   logic        pc_advance_o;
   logic        inst_req;
   logic        inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   int check_count = 0;
   int error_count = 0;

   // Reference model: request awaiting acceptance, response outstanding, response doomed, result held.
   logic        m_req_pending;
   logic        m_resp_pending;
   logic        m_killed;
   logic        m_held;
   logic [31:0] m_addr;
   logic [31:0] m_inst;
   logic [31:0] m_pc;
   logic        m_exc;

   inst_fetch_if #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .pc_i         (pc_i),
      .fetch_en     (fetch_en),
      .flush        (flush),
      .id_ready_i   (id_ready_i),
      .inst_valid_o (inst_valid_o),
      .inst_o       (inst_o),
      .pc_o         (pc_o),
      .exc_adel_o   (exc_adel_o),
      .pc_advance_o (pc_advance_o),
      .inst_req     (inst_req),
      .inst_wr      (inst_wr),
      .inst_size    (inst_size),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      m_req_pending  = 1'b0;
      m_resp_pending = 1'b0;
      m_killed       = 1'b0;
      m_held         = 1'b0;
      m_addr         = '0;
      m_inst         = '0;
      m_pc           = '0;
      m_exc          = 1'b0;
   endtask

   // One clock of the bus/decode protocol as seen from outside, one outstanding request at most.
   task automatic modelStep(input logic fe, input logic fl, input logic rdy, input logic aok,
                            input logic dok, input logic [31:0] rd, input logic [31:0] pc);
      if (m_held) begin
         if (fl || rdy) begin
            m_held = 1'b0;
            m_exc  = 1'b0;
         end
      end else if (m_req_pending) begin
         if (fl) m_killed = 1'b1;
         if (aok) begin
            m_req_pending  = 1'b0;
            m_resp_pending = 1'b1;
         end
      end else if (m_resp_pending) begin
         if (m_killed) begin
            if (dok) begin
               m_resp_pending = 1'b0;
               m_killed       = 1'b0;
            end
         end else if (dok) begin
            m_resp_pending = 1'b0;
            if (!fl) begin
               m_held = 1'b1;
               m_inst = rd;
               m_pc   = m_addr;
               m_exc  = 1'b0;
            end
         end else if (fl) begin
            m_killed = 1'b1;
         end
      end else if (fe && !fl) begin
         m_addr = pc;
         if (pc % 4 == 0) begin
            m_req_pending = 1'b1;
         end else begin
            m_held = 1'b1;
            m_exc  = 1'b1;
            m_inst = '0;
            m_pc   = pc;
         end
      end
   endtask

   task automatic applyStimulus(input logic fe, input logic fl, input logic rdy, input logic aok,
                                input logic dok, input logic [31:0] rd, input logic [31:0] pc);
      @(negedge clk);
      fetch_en     = fe;
      flush        = fl;
      id_ready_i   = rdy;
      inst_addr_ok = aok;
      inst_data_ok = dok;
      inst_rdata   = rd;
      pc_i         = pc;
      #1;
      checkOutput("inst_req", 32'(inst_req), 32'(m_req_pending));
      checkOutput("inst_valid_o", 32'(inst_valid_o), 32'(m_held));
      checkOutput("pc_advance_o", 32'(pc_advance_o), 32'(m_held && rdy && !fl));
      checkOutput("exc_adel_o", 32'(exc_adel_o), 32'(m_held && m_exc));
      checkOutput("inst_addr", inst_addr, m_addr);
      if (m_held) begin
         checkOutput("inst_o", inst_o, m_inst);
         checkOutput("pc_o", pc_o, m_pc);
      end
      @(posedge clk);
      modelStep(fe, fl, rdy, aok, dok, rd, pc);
   endtask

   task automatic applyReset();
      @(negedge clk);
      resetn = 1'b0;
      #1;
      modelReset();
      checkOutput("reset inst_req", 32'(inst_req), 32'd0);
      checkOutput("reset inst_valid_o", 32'(inst_valid_o), 32'd0);
      checkOutput("reset pc_advance_o", 32'(pc_advance_o), 32'd0);
      checkOutput("reset exc_adel_o", 32'(exc_adel_o), 32'd0);
      checkOutput("reset inst_o", inst_o, 32'd0);
      checkOutput("reset pc_o", pc_o, 32'd0);
      checkOutput("reset inst_addr", inst_addr, 32'd0);
      checkOutput("inst_wr", 32'(inst_wr), 32'd0);
      fetch_en     = 1'b0;
      flush        = 1'b0;
      id_ready_i   = 1'b0;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      resetn       = 1'b1;
      fetch_en     = 1'b0;
      flush        = 1'b0;
      id_ready_i   = 1'b0;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = '0;
      pc_i         = '0;
      modelReset();
      applyReset();

      // Zero-wait fetch, consumed immediately.
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 1, 1, 32'h3c1d0000, 32'hbfc00000);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'hbfc00004);

      // Address acceptance delayed three cycles.
      applyStimulus(1, 0, 0, 0, 0, 32'h0, 32'hbfc00004);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
      applyStimulus(0, 0, 0, 1, 0, 32'h0, 32'h0);
      applyStimulus(0, 0, 0, 0, 1, 32'h11223344, 32'h0);
      applyStimulus(0, 0, 1, 0, 0, 32'h0, 32'h0);

      // Flush while waiting for data; late response must be dropped.
      applyStimulus(1, 0, 0, 0, 0, 32'h0, 32'hbfc00008);
      applyStimulus(0, 0, 0, 1, 0, 32'h0, 32'h0);
      applyStimulus(0, 1, 1, 0, 0, 32'h0, 32'h0);
      applyStimulus(0, 0, 1, 0, 0, 32'h0, 32'h0);
      applyStimulus(0, 0, 1, 0, 1, 32'hdeadbeef, 32'h0);
      applyStimulus(0, 0, 1, 0, 0, 32'h0, 32'h0);

      // Misaligned PC, held unconsumed for five cycles, then flush together with ready.
      applyStimulus(1, 0, 0, 1, 1, 32'h55555555, 32'hbfc00002);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
      applyStimulus(0, 1, 1, 0, 0, 32'h0, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);

      // Reset in the middle of a data wait; a stray response afterwards is ignored.
      applyStimulus(1, 0, 0, 1, 0, 32'h0, 32'hbfc00010);
      applyStimulus(0, 0, 0, 1, 0, 32'h0, 32'h0);
      applyReset();
      applyStimulus(0, 0, 1, 0, 1, 32'hcafef00d, 32'h0);
      applyStimulus(0, 0, 1, 0, 0, 32'h0, 32'h0);

      for (int i = 0; i < 3000; i++) begin
         logic [31:0] rnd_pc;
         rnd_pc = $urandom;
         if ($urandom_range(0, 3) != 0) rnd_pc[1:0] = 2'b00;
         applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                       1'($urandom_range(0, 2) != 0), $urandom, rnd_pc);
         if ($urandom_range(0, 499) == 0) applyReset();
      end

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
